// File: rtl/uart_baud_gen_frac.sv
// Fractional baud-rate generator: produces a one-cycle oversample tick
// (s_tick) and a one-cycle bit tick (b_tick) from a runtime-loadable
// integer.fraction divisor held in shadow/active register pairs.
module uart_baud_gen_frac #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAC_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              s_tick,
  output logic              b_tick,
  output logic              load_pending
);

  localparam int unsigned OS_W  = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned CNT_W = DIV_W + 1;

  // Reset-default divisor in units of 1/2^FRAC_W clock.
  localparam longint unsigned DEF_D =
    (64'(CLK_FREQ) << FRAC_W) / (64'(BAUD_RATE) * 64'(OVERSAMPLE));
  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEF_D >> FRAC_W);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_D);

  logic [DIV_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;
  logic [DIV_W-1:0]  sh_int;
  logic [FRAC_W-1:0] sh_frac;

  logic [CNT_W-1:0]  cnt;
  logic [OS_W-1:0]   os_cnt;
  logic [FRAC_W-1:0] acc;
  logic              carry;

  logic [DIV_W-1:0]  eff_int;
  logic [CNT_W-1:0]  period_m1;
  logic [FRAC_W:0]   frac_sum;
  logic              tick_now;
  logic              os_last;
  logic              apply_now;

  // Period length, tick decision and apply point derived from current state.
  always_comb begin
    eff_int = act_int;
    if (act_int[DIV_W-1:1] == '0) begin
      eff_int = DIV_W'(2);
    end
    period_m1 = CNT_W'(eff_int) + CNT_W'(carry) - CNT_W'(1);
    tick_now  = en && (cnt == period_m1);
    os_last   = (os_cnt == OS_W'(OVERSAMPLE - 1));
    frac_sum  = {1'b0, acc} + {1'b0, act_frac};
    // While running, a new divisor only takes effect on a period boundary.
    apply_now = load_pending && (tick_now || !en);
  end

  // Cycle counter within the current period; registers s_tick at its end.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt    <= '0;
      s_tick <= 1'b0;
    end else if (tick_now) begin
      cnt    <= '0;
      s_tick <= 1'b1;
    end else begin
      cnt    <= cnt + CNT_W'(1);
      s_tick <= 1'b0;
    end
  end

  // Oversample counter; b_tick accompanies every OVERSAMPLE-th s_tick.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      os_cnt <= '0;
      b_tick <= 1'b0;
    end else if (tick_now) begin
      os_cnt <= os_last ? '0 : os_cnt + OS_W'(1);
      b_tick <= os_last;
    end else begin
      b_tick <= 1'b0;
    end
  end

  // Fractional accumulator; the carry stretches the next period by one cycle.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      acc   <= '0;
      carry <= 1'b0;
    end else if (tick_now) begin
      if (apply_now) begin
        acc   <= '0;
        carry <= 1'b0;
      end else begin
        {carry, acc} <= frac_sum;
      end
    end
  end

  // Shadow capture and glitch-free transfer to the active divisor.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_int      <= DEF_INT;
      act_frac     <= DEF_FRAC;
      sh_int       <= '0;
      sh_frac      <= '0;
      load_pending <= 1'b0;
    end else begin
      if (apply_now) begin
        act_int  <= sh_int;
        act_frac <= sh_frac;
      end
      // A fresh load on the apply cycle keeps the request alive for the next boundary.
      if (div_load) begin
        sh_int       <= div_int;
        sh_frac      <= div_frac;
        load_pending <= 1'b1;
      end else if (apply_now) begin
        load_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Self-checking bench for uart_baud_gen_frac: directed scenarios followed by
// randomized traffic, compared every cycle against an arithmetic tick model.
module tb_uart_baud_gen_frac;

  localparam int unsigned CLK_FREQ   = 100_000_000;
  localparam int unsigned BAUD_RATE  = 9600;
  localparam int unsigned OS         = 16;
  localparam int unsigned DIV_W      = 16;
  localparam int unsigned FRAC_W     = 4;
  localparam int          FSCALE     = 1 << FRAC_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              s_tick;
  logic              b_tick;
  logic              load_pending;

  always #5 clk = ~clk;

  uart_baud_gen_frac #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OS),
    .DIV_W     (DIV_W),
    .FRAC_W    (FRAC_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .div_int     (div_int),
    .div_frac    (div_frac),
    .div_load    (div_load),
    .s_tick      (s_tick),
    .b_tick      (b_tick),
    .load_pending(load_pending)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: tick times are scheduled as absolute edge numbers.
  longint def_d;
  int     def_int, def_frac;
  longint cyc = 0;
  longint next_edge;
  int     m_ai, m_af, m_si, m_sf;
  bit     m_pend, m_run;
  int     frac_n, os_n;
  bit     e_s, e_b;

  // Length of the k-th period since the accumulator was last cleared:
  // the carry is the step in floor(k*frac/2^F).
  function automatic int period(int ai, int af, int k);
    int eff;
    eff = (ai < 2) ? 2 : ai;
    if (k == 0) return eff;
    return eff + (k * af) / FSCALE - ((k - 1) * af) / FSCALE;
  endfunction

  task automatic model_edge(bit r, bit e, bit l, int di, int df);
    e_s = 1'b0;
    e_b = 1'b0;
    if (r) begin
      m_ai = def_int; m_af = def_frac; m_si = 0; m_sf = 0;
      m_pend = 1'b0; m_run = 1'b0;
    end else begin
      if (!e) begin
        m_run = 1'b0;
        if (m_pend) begin m_ai = m_si; m_af = m_sf; m_pend = 1'b0; end
      end else begin
        if (!m_run) begin
          m_run = 1'b1; frac_n = 0; os_n = 0;
          next_edge = cyc + period(m_ai, m_af, 0) - 1;
        end
        if (cyc == next_edge) begin
          e_s = 1'b1;
          os_n++;
          e_b = ((os_n % OS) == 0);
          if (m_pend) begin
            m_ai = m_si; m_af = m_sf; m_pend = 1'b0; frac_n = 0;
          end else begin
            frac_n++;
          end
          next_edge = cyc + period(m_ai, m_af, frac_n);
        end
      end
      if (l) begin m_si = di; m_sf = df; m_pend = 1'b1; end
    end
    cyc++;
  endtask

  task automatic chk(string tag, logic obs, logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic step(bit r, bit e, bit l, int di, int df);
    rst      = r;
    en       = e;
    div_load = l;
    div_int  = DIV_W'(di);
    div_frac = FRAC_W'(df);
    @(posedge clk);
    model_edge(r, e, l, di, df);
    #1;
    chk("s_tick", s_tick, e_s);
    chk("b_tick", b_tick, e_b);
    chk("load_pending", load_pending, m_pend);
  endtask

  task automatic run(int n, bit e);
    for (int i = 0; i < n; i++) step(1'b0, e, 1'b0, 0, 0);
  endtask

  initial begin
    def_d    = (longint'(CLK_FREQ) * FSCALE) / (longint'(BAUD_RATE) * OS);
    def_int  = int'(def_d / FSCALE);
    def_frac = int'(def_d % FSCALE);
    m_ai = def_int; m_af = def_frac; m_si = 0; m_sf = 0;
    m_pend = 1'b0; m_run = 1'b0; frac_n = 0; os_n = 0; next_edge = 0;
    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_int = '0; div_frac = '0;

    // Reset, with a load strobe that reset must override.
    step(1, 0, 1, 33, 5);
    step(1, 0, 0, 0, 0);
    chk("reset_s_tick", s_tick, 1'b0);
    chk("reset_pending", load_pending, 1'b0);

    // Default divisor: s_tick every 651, first b_tick after 16 s_ticks.
    run(11000, 1);

    // Fractional 10 + 8/16 loaded while disabled.
    step(0, 0, 1, 10, 8);
    run(2, 0);
    run(400, 1);

    // Runtime reload mid-period from the default divisor.
    step(1, 0, 0, 0, 0);
    run(300, 1);
    step(0, 1, 1, 100, 0);
    run(1000, 1);

    // Clamp and last-wins: 1/0 overwritten by 5/0 before the boundary.
    step(0, 1, 1, 1, 0);
    run(10, 1);
    step(0, 1, 1, 5, 0);
    run(200, 1);
    step(0, 1, 1, 0, 0);
    run(100, 1);

    // en toggled low for 3 cycles mid-period.
    step(0, 1, 1, 10, 8);
    run(50, 1);
    run(3, 0);
    run(400, 1);

    // Reset during a pending load with 10/8 active.
    run(5, 1);
    step(0, 1, 1, 20, 3);
    step(1, 1, 0, 0, 0);
    run(700, 1);

    // Randomized traffic; loads are favoured right after an s_tick.
    for (int i = 0; i < 15000; i++) begin
      bit r, e, l;
      r = ($urandom_range(0, 2999) == 0);
      e = ($urandom_range(0, 199) != 0);
      l = e_s ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 149) == 0);
      step(r, e, l, int'($urandom_range(0, 24)), int'($urandom_range(0, FSCALE - 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_baud_gen_frac.md
Name: uart_baud_gen_frac

Overview:
Programmable fractional baud-rate generator for the UART TX/RX datapath. It produces a one-cycle oversample tick (s_tick, OVERSAMPLE per bit) and a one-cycle bit tick (b_tick). The divisor has integer and fractional parts and can be reloaded at runtime without glitches. It replaces fixed, compile-time-only tick generation, so baud rate changes need no re-synthesis and rounding error no longer accumulates.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz.
BAUD_RATE, 9600, baud rate used for the reset-default divisor.
OVERSAMPLE, 16, s_ticks per bit; must be 2 or more.
DIV_W, 16, width of the integer divisor.
FRAC_W, 4, width of the fractional divisor (units of 1/2^FRAC_W clock).

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
en  in  1  generator enable.
div_int  in  DIV_W  integer clocks per s_tick.
div_frac  in  FRAC_W  fractional clocks per s_tick.
div_load  in  1  one-cycle strobe; captures div_int/div_frac into the shadow registers.
s_tick  out  1  oversample tick, one cycle wide.
b_tick  out  1  bit tick, one cycle wide, coincident with every OVERSAMPLE-th s_tick.
load_pending  out  1  high while a captured divisor is waiting to be applied.

Behaviour:
- Reset-default divisor: D = floor(CLK_FREQ*2^FRAC_W/(BAUD_RATE*OVERSAMPLE)). act_int = D>>FRAC_W; act_frac = D mod 2^FRAC_W. With the defaults this gives 651 / 0.
- rst sampled high, effective the next cycle:
  - cycle counter, oversample counter, fractional accumulator (acc) and carry c all go to 0;
  - s_tick, b_tick and load_pending go to 0;
  - act_* are loaded with the defaults and the shadow registers are cleared.
  - Mid-operation reset aborts the current period; any pending load is discarded.
- Effective integer divisor: eff_int = max(act_int, 2). Values 0 and 1 clamp to 2.
- Period length P = eff_int + c cycles. The first period after reset, after enable, or after a load is applied has c = 0.
- Tick timing:
  - en is first sampled high at edge E0. s_tick is registered and is high in the cycle after edge E0+P-1.
  - Consecutive s_ticks are exactly P cycles apart, with P re-evaluated each period.
- Fractional accumulation: at each s_tick, {c, acc} <= acc + act_frac (FRAC_W+1 bits). The resulting c sets the next period. Average period = act_int + act_frac/2^FRAC_W.
- Oversample counter:
  - advances on each s_tick and wraps from OVERSAMPLE-1 to 0;
  - b_tick is high in the same cycle as the s_tick on which the counter value is OVERSAMPLE-1;
  - the first b_tick is on the OVERSAMPLE-th s_tick.
- en low:
  - cycle counter, oversample counter, acc and c are held at 0 the next cycle;
  - s_tick and b_tick are 0.
  - Re-enabling restarts timing from scratch.
- div_load:
  - captures the inputs into the shadow registers and sets load_pending the next cycle.
  - Apply point:
    - if en = 1, the shadow values are applied at the next s_tick boundary; that s_tick still ends the old period, the following period uses the new divisor, and acc and c are cleared;
    - if en = 0, they are applied on the next cycle.
  - load_pending clears when the values are applied.
  - A second div_load before the apply point overwrites the shadow registers (last wins).
  - div_load in the same cycle as an s_tick is captured and applied at the following s_tick.
  - div_load together with rst: rst wins.
- No combinational path from any input to any output.

Test Plan:
- Defaults: rst pulse, then en=1 -> s_tick every 651 cycles; b_tick every 10416 cycles; first s_tick 651 cycles after en is first sampled high.
- Fractional: load div_int=10, div_frac=8 with en=0, then en=1 -> s_tick intervals 10,10,11,10,11,…; exactly 16 b_tick-to-b_tick spacing of 168 cycles.
- Runtime reload: en=1 at 651, pulse div_load with 100/0 mid-period -> current period completes at 651, load_pending drops at that s_tick, following intervals are 100.
- Clamp and last-wins: load 1/0 then 5/0 before the boundary -> intervals become 5; separately load 0/0 -> intervals of 2.
- en toggling: deassert en mid-period for 3 cycles and reassert -> no ticks while low, next s_tick a full P after re-enable, oversample phase restarts (b_tick after 16 s_ticks).
- Reset mid-operation: rst during a pending load with div 10/8 active -> load_pending=0, interval returns to 651, no spurious tick in the cycle after reset.
